// File: rtl/ecliptic_fclass_unit_if.sv
// Request/response bundle for the FCLASS unit: decoupled valid/ready request
// carrying operand and tag, and a tagged class-mask response.
interface ecliptic_fclass_unit_if #(
  parameter int FLEN  = 32,
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [FLEN-1:0]  req_src;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [9:0]       rsp_res;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_src, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_tag
  );

  modport slave (
    input  req_valid, req_src, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_tag
  );
endinterface

// File: rtl/ecliptic_fclass_unit.sv
// Floating-point classification unit: produces the RISC-V FCLASS one-hot mask
// for a parametrised IEEE-754 format, with optional NaN-box checking, and
// queues tagged results in a small output FIFO.
module ecliptic_fclass_unit #(
  parameter int FLEN         = 32,
  parameter int EXP_W        = 8,
  parameter int MAN_W        = 23,
  parameter int NANBOX_CHECK = 1,
  parameter int TAG_W        = 4,
  parameter int DEPTH        = 2
) (
  input  logic                    clk,
  input  logic                    nrst,
  ecliptic_fclass_unit_if.slave   bus,
  input  logic                    flush,
  output logic                    snan_seen
);

  localparam int FMT_W = 1 + EXP_W + MAN_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  // Reject parameter sets the datapath cannot represent.
  if (FMT_W > FLEN) begin : g_bad_fmt
    $error("ecliptic_fclass_unit: format width exceeds FLEN");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("ecliptic_fclass_unit: DEPTH must be at least 1");
  end

  // One-hot FCLASS mask from the unpacked fields.
  function automatic logic [9:0] fclass_f(input logic sgn,
                                          input logic [EXP_W-1:0] e,
                                          input logic [MAN_W-1:0] m);
    logic [9:0] r;
    r = 10'h000;
    if (&e) begin
      if (m == {MAN_W{1'b0}}) r = sgn ? 10'h001 : 10'h080;
      else if (m[MAN_W-1])    r = 10'h200;
      else                    r = 10'h100;
    end else if (e == {EXP_W{1'b0}}) begin
      if (m == {MAN_W{1'b0}}) r = sgn ? 10'h008 : 10'h010;
      else                    r = sgn ? 10'h004 : 10'h020;
    end else begin
      r = sgn ? 10'h002 : 10'h040;
    end
    return r;
  endfunction

  // Circular pointer advance, wrapping at DEPTH rather than a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc_f(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_LAST) n = {PTR_W{1'b0}};
    else               n = p + PTR_W'(1);
    return n;
  endfunction

  logic             box_bad_s;
  logic [9:0]       cls_s;
  logic             push_s;
  logic             pop_s;
  logic             ready_r;
  logic             snan_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [9:0]       res_mem_r [DEPTH];
  logic [TAG_W-1:0] tag_mem_r [DEPTH];

  // Upper register bits must be all-ones for a narrower operand to be valid.
  if (NANBOX_CHECK != 0 && FLEN > FMT_W) begin : g_box
    assign box_bad_s = ~(&bus.req_src[FLEN-1:FMT_W]);
  end else begin : g_nobox
    assign box_bad_s = 1'b0;
  end

  // Classify the incoming operand; a bad NaN-box forces canonical qNaN.
  always_comb begin
    cls_s = 10'h000;
    if (box_bad_s) begin
      cls_s = 10'h200;
    end else begin
      cls_s = fclass_f(bus.req_src[FMT_W-1], bus.req_src[FMT_W-2:MAN_W],
                       bus.req_src[MAN_W-1:0]);
    end
  end

  assign bus.req_ready = ready_r & (cnt_r != CNT_FULL);
  assign bus.rsp_valid = (cnt_r != {CNT_W{1'b0}});
  assign push_s        = bus.req_valid & bus.req_ready & ~flush;
  assign pop_s         = bus.rsp_valid & bus.rsp_ready & ~flush;
  assign snan_seen     = snan_r;

  // Head entry is presented only while the FIFO holds data.
  always_comb begin
    bus.rsp_res = 10'h000;
    bus.rsp_tag = {TAG_W{1'b0}};
    if (bus.rsp_valid) begin
      bus.rsp_res = res_mem_r[rd_ptr_r];
      bus.rsp_tag = tag_mem_r[rd_ptr_r];
    end else begin
      bus.rsp_res = 10'h000;
      bus.rsp_tag = {TAG_W{1'b0}};
    end
  end

  // FIFO control, start-up ready and sticky sNaN flag; flush wins over all.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ready_r  <= 1'b0;
      snan_r   <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      ready_r <= 1'b1;
      if (flush) begin
        snan_r   <= 1'b0;
        cnt_r    <= {CNT_W{1'b0}};
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= ptr_inc_f(wr_ptr_r);
        else        wr_ptr_r <= wr_ptr_r;
        if (pop_s)  rd_ptr_r <= ptr_inc_f(rd_ptr_r);
        else        rd_ptr_r <= rd_ptr_r;
        case ({push_s, pop_s})
          2'b10:   cnt_r <= cnt_r + CNT_W'(1);
          2'b01:   cnt_r <= cnt_r - CNT_W'(1);
          default: cnt_r <= cnt_r;
        endcase
        if (push_s && cls_s[8]) snan_r <= 1'b1;
        else                    snan_r <= snan_r;
      end
    end
  end

  // FIFO storage; cleared on reset so no pre-reset data can ever resurface.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_mem_r[i] <= 10'h000;
        tag_mem_r[i] <= {TAG_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        res_mem_r[wr_ptr_r] <= cls_s;
        tag_mem_r[wr_ptr_r] <= bus.req_tag;
      end else begin
        res_mem_r[wr_ptr_r] <= res_mem_r[wr_ptr_r];
        tag_mem_r[wr_ptr_r] <= tag_mem_r[wr_ptr_r];
      end
    end
  end

endmodule

// File: tb/tb_ecliptic_fclass_unit.sv
// Bench for ecliptic_fclass_unit: three format instances (single, boxed
// single in 64-bit register, half) compared against a field-arithmetic
// classifier and a queue-based FIFO model.
module tb_ecliptic_fclass_unit;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic flush_d = 1'b0, flush_w = 1'b0, flush_h = 1'b0;
  logic snan_d, snan_w, snan_h;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ecliptic_fclass_unit_if #(.FLEN(32), .TAG_W(4)) ifc_d ();
  ecliptic_fclass_unit_if #(.FLEN(64), .TAG_W(4)) ifc_w ();
  ecliptic_fclass_unit_if #(.FLEN(16), .TAG_W(4)) ifc_h ();

  ecliptic_fclass_unit u_d (.clk(clk), .nrst(nrst), .bus(ifc_d), .flush(flush_d), .snan_seen(snan_d));
  ecliptic_fclass_unit #(.FLEN(64), .EXP_W(8), .MAN_W(23)) u_w (
    .clk(clk), .nrst(nrst), .bus(ifc_w), .flush(flush_w), .snan_seen(snan_w));
  ecliptic_fclass_unit #(.FLEN(16), .EXP_W(5), .MAN_W(10)) u_h (
    .clk(clk), .nrst(nrst), .bus(ifc_h), .flush(flush_h), .snan_seen(snan_h));

  // Model state for the default instance.
  logic [13:0] q[$];
  bit          rdy_m = 1'b0;
  bit          snan_m = 1'b0;
  bit          sn_w = 1'b0, sn_h = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference classifier working on field values extracted arithmetically.
  function automatic logic [9:0] fclass_ref(input logic [63:0] src, input int flen,
                                            input int ew, input int mw, input bit nb);
    int fmt;
    int idx;
    logic [63:0] e, m, emax, sg;
    fmt = 1 + ew + mw;
    if (nb && flen > fmt && ((src >> fmt) != ((64'h1 << (flen - fmt)) - 64'h1)))
      return 10'h200;
    sg   = (src >> (fmt - 1)) & 64'h1;
    e    = (src >> mw) & ((64'h1 << ew) - 64'h1);
    m    = src & ((64'h1 << mw) - 64'h1);
    emax = (64'h1 << ew) - 64'h1;
    if (e == emax)
      idx = (m == 64'h0) ? ((sg != 64'h0) ? 0 : 7) : ((((m >> (mw - 1)) & 64'h1) != 64'h0) ? 9 : 8);
    else if (e == 64'h0)
      idx = (m == 64'h0) ? ((sg != 64'h0) ? 3 : 4) : ((sg != 64'h0) ? 2 : 5);
    else
      idx = (sg != 64'h0) ? 1 : 6;
    return 10'h001 << idx;
  endfunction

  // Random operand biased toward zero/all-ones exponents and zero mantissas.
  function automatic logic [63:0] rnd_src(input int flen, input int ew, input int mw);
    logic [63:0] s, emask;
    int fmt;
    fmt   = 1 + ew + mw;
    s     = {$urandom, $urandom};
    emask = ((64'h1 << ew) - 64'h1) << mw;
    case ($urandom_range(0, 2))
      0: s = s & ~emask;
      1: s = s | emask;
      default: s = s;
    endcase
    if ($urandom_range(0, 3) == 0) s = s & ~((64'h1 << mw) - 64'h1);
    if (flen > fmt && $urandom_range(0, 3) != 0) s = s | ~((64'h1 << fmt) - 64'h1);
    if (flen < 64) s = s & ((64'h1 << flen) - 64'h1);
    return s;
  endfunction

  // One cycle on the default instance: drive, check against model, step model.
  task automatic cyc_d(input bit v, input logic [31:0] s, input logic [3:0] t,
                       input bit rr, input bit fl);
    logic [9:0]  c;
    logic [13:0] head;
    bit exp_rdy, push, pop;
    ifc_d.req_valid = v;
    ifc_d.req_src   = s;
    ifc_d.req_tag   = t;
    ifc_d.rsp_ready = rr;
    flush_d         = fl;
    c       = fclass_ref({32'h0, s}, 32, 8, 23, 1'b1);
    exp_rdy = rdy_m && (q.size() < 2);
    head    = (q.size() != 0) ? q[0] : 14'h0;
    #4;
    chk("d_req_ready", ifc_d.req_ready, exp_rdy);
    chk("d_rsp_valid", ifc_d.rsp_valid, q.size() != 0);
    chk("d_rsp_res", ifc_d.rsp_res, head[13:4]);
    chk("d_rsp_tag", ifc_d.rsp_tag, head[3:0]);
    chk("d_snan_seen", snan_d, snan_m);
    @(posedge clk); #1;
    push  = v && exp_rdy;
    pop   = rr && (q.size() != 0);
    rdy_m = 1'b1;
    if (fl) begin
      q.delete();
      snan_m = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back({c, t});
        if (c == 10'h100) snan_m = 1'b1;
      end
    end
  endtask

  task automatic cls_w(input logic [63:0] s, input logic [9:0] e);
    ifc_w.req_valid = 1'b1; ifc_w.req_src = s; ifc_w.req_tag = s[3:0]; ifc_w.rsp_ready = 1'b1;
    #4 chk("w_req_ready", ifc_w.req_ready, 1'b1);
    @(posedge clk); #1;
    ifc_w.req_valid = 1'b0;
    if (e == 10'h100) sn_w = 1'b1;
    #4;
    chk("w_rsp_valid", ifc_w.rsp_valid, 1'b1);
    chk("w_rsp_res", ifc_w.rsp_res, e);
    chk("w_rsp_tag", ifc_w.rsp_tag, s[3:0]);
    chk("w_snan_seen", snan_w, sn_w);
    @(posedge clk); #1;
  endtask

  task automatic cls_h(input logic [15:0] s, input logic [9:0] e);
    ifc_h.req_valid = 1'b1; ifc_h.req_src = s; ifc_h.req_tag = s[7:4]; ifc_h.rsp_ready = 1'b1;
    #4 chk("h_req_ready", ifc_h.req_ready, 1'b1);
    @(posedge clk); #1;
    ifc_h.req_valid = 1'b0;
    if (e == 10'h100) sn_h = 1'b1;
    #4;
    chk("h_rsp_valid", ifc_h.rsp_valid, 1'b1);
    chk("h_rsp_res", ifc_h.rsp_res, e);
    chk("h_rsp_tag", ifc_h.rsp_tag, s[7:4]);
    chk("h_snan_seen", snan_h, sn_h);
    @(posedge clk); #1;
  endtask

  logic [31:0] dsrc [6] = '{32'h7FC00000, 32'h7F800001, 32'hFF800000,
                            32'h80000001, 32'h00000000, 32'h3F800000};
  logic [9:0]  dexp [6] = '{10'h200, 10'h100, 10'h001, 10'h004, 10'h010, 10'h040};

  initial begin
    logic [63:0] r64;
    logic [31:0] r32;
    ifc_d.req_valid = 1'b0; ifc_d.req_src = '0; ifc_d.req_tag = '0; ifc_d.rsp_ready = 1'b0;
    ifc_w.req_valid = 1'b0; ifc_w.req_src = '0; ifc_w.req_tag = '0; ifc_w.rsp_ready = 1'b0;
    ifc_h.req_valid = 1'b0; ifc_h.req_src = '0; ifc_h.req_tag = '0; ifc_h.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", ifc_d.req_ready, 1'b0);
    chk("rst_rsp_valid", ifc_d.rsp_valid, 1'b0);
    chk("rst_rsp_res", ifc_d.rsp_res, 10'h000);
    chk("rst_snan_seen", snan_d, 1'b0);
    #2 nrst = 1'b1;
    @(posedge clk); #1;
    rdy_m = 1'b1;

    // Boxed single inside a 64-bit register.
    cls_w(64'hFFFFFFFF_3F800000, 10'h040);
    cls_w(64'h00000000_3F800000, 10'h200);
    cls_w(64'h00000000_7F800001, 10'h200);
    cls_w(64'hFFFFFFFF_7F800001, 10'h100);
    for (int i = 0; i < 40; i++) begin
      r64 = rnd_src(64, 8, 23);
      cls_w(r64, fclass_ref(r64, 64, 8, 23, 1'b1));
    end

    // Half precision.
    cls_h(16'h7C00, 10'h080);
    cls_h(16'h0001, 10'h020);
    cls_h(16'h8000, 10'h008);
    cls_h(16'hFE00, 10'h200);
    for (int i = 0; i < 40; i++) begin
      r64 = rnd_src(16, 5, 10);
      cls_h(r64[15:0], fclass_ref(r64, 16, 5, 10, 1'b1));
    end

    // Directed single-precision stream, back to back.
    for (int i = 0; i < 6; i++) begin
      cyc_d(1'b1, dsrc[i], 4'(i), 1'b1, 1'b0);
      chk("d_dir_res", ifc_d.rsp_res, dexp[i]);
      chk("d_dir_tag", ifc_d.rsp_tag, 4'(i));
      chk("d_dir_snan", snan_d, i >= 1);
    end
    cyc_d(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Backpressure: A, B fill the FIFO, C waits until A leaves.
    cyc_d(1'b1, 32'h3F800000, 4'hA, 1'b0, 1'b0);
    cyc_d(1'b1, 32'h80000000, 4'hB, 1'b0, 1'b0);
    cyc_d(1'b1, 32'h7F800000, 4'hC, 1'b0, 1'b0);
    cyc_d(1'b1, 32'h7F800000, 4'hC, 1'b0, 1'b0);
    cyc_d(1'b1, 32'h7F800000, 4'hC, 1'b1, 1'b0);
    cyc_d(1'b1, 32'h7F800000, 4'hC, 1'b1, 1'b0);
    cyc_d(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    cyc_d(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Simultaneous push and pop with one entry held.
    cyc_d(1'b1, 32'h00000001, 4'h1, 1'b0, 1'b0);
    cyc_d(1'b1, 32'h80800000, 4'h2, 1'b1, 1'b0);
    cyc_d(1'b1, 32'hFFC00000, 4'h3, 1'b1, 1'b0);
    cyc_d(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Flush with two entries and the sticky flag set.
    cyc_d(1'b1, 32'h7F800001, 4'h4, 1'b0, 1'b0);
    cyc_d(1'b1, 32'h3F800000, 4'h5, 1'b0, 1'b0);
    cyc_d(1'b1, 32'h7F800001, 4'h6, 1'b1, 1'b1);
    cyc_d(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r64 = rnd_src(32, 8, 23);
      r32 = r64[31:0];
      cyc_d(1'($urandom_range(0, 1)), r32, 4'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 24) == 0);
    end

    // Asynchronous reset mid-operation with two entries queued.
    cyc_d(1'b1, 32'h7F800001, 4'h7, 1'b0, 1'b0);
    cyc_d(1'b1, 32'h3F800000, 4'h8, 1'b0, 1'b0);
    cyc_d(1'b1, 32'h3F800000, 4'h9, 1'b0, 1'b0);
    ifc_d.req_valid = 1'b0;
    #2 nrst = 1'b0;
    #1;
    chk("arst_req_ready", ifc_d.req_ready, 1'b0);
    chk("arst_rsp_valid", ifc_d.rsp_valid, 1'b0);
    chk("arst_rsp_res", ifc_d.rsp_res, 10'h000);
    chk("arst_rsp_tag", ifc_d.rsp_tag, 4'h0);
    chk("arst_snan_seen", snan_d, 1'b0);
    q.delete();
    snan_m = 1'b0;
    rdy_m  = 1'b0;
    @(posedge clk); #3;
    nrst = 1'b1;
    cyc_d(1'b1, 32'h40000000, 4'hD, 1'b1, 1'b0);
    cyc_d(1'b1, 32'h40000000, 4'hD, 1'b1, 1'b0);
    cyc_d(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    cyc_d(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ecliptic_fclass_unit.md
Name: ecliptic_fclass_unit

Overview:
- Parametrised floating-point classification unit with a decoupled valid/ready request/response interface and a tagged output FIFO. Single pipeline.
- Produces the RISC-V FCLASS 10-bit one-hot mask for any IEEE-754 binary format up to FLEN bits.
- Optionally checks NaN-boxing when the format is narrower than the register.
- Sits beside the FPU register read path and serves FCLASS for half/single/double through one instance per format.

Parameters:
- FLEN, 32, source operand width in bits.
- EXP_W, 8, exponent field width.
- MAN_W, 23, mantissa field width; format width FMT_W = 1+EXP_W+MAN_W, must satisfy FMT_W <= FLEN.
- NANBOX_CHECK, 1, when 1 and FLEN > FMT_W, improperly boxed operands classify as quiet NaN.
- TAG_W, 4, request tag width, returned unchanged with the response.
- DEPTH, 2, output FIFO entries, must be >= 1.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready at a clk rising edge.
- req_src  in  FLEN  operand bits.
- req_tag  in  TAG_W  request tag.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer ready; a pop occurs when rsp_valid & rsp_ready.
- rsp_res  out  10  class mask of the head entry.
- rsp_tag  out  TAG_W  tag of the head entry.
- flush  in  1  synchronous clear of FIFO contents and the sticky flag.
- snan_seen  out  1  sticky: set when any accepted operand classifies as signalling NaN.

Behaviour:
- Field extraction from the low FMT_W bits of req_src:
  - sign = bit FMT_W-1
  - exp = bits [FMT_W-2:MAN_W]
  - man = bits [MAN_W-1:0]
- Classes:
  - qnan: exp all-ones and man MSB = 1.
  - snan: exp all-ones, man MSB = 0, man != 0.
  - inf: exp all-ones and man == 0.
  - zero: exp == 0 and man == 0.
  - subnormal: exp == 0 and man != 0.
  - normal: everything else.
  - Each of inf/normal/subnormal/zero is split by sign.
- NaN-boxing: if NANBOX_CHECK = 1, FLEN > FMT_W, and req_src[FLEN-1:FMT_W] is not all-ones, the result is qnan only. Field values are ignored and snan_seen is not set.
- Mask bit order:
  - 0 ninf, 1 nnml, 2 nsnml, 3 nzero, 4 pzero
  - 5 psnml, 6 pnml, 7 pinf, 8 snan, 9 qnan
  - Exactly one bit is set per result.
- Classification is combinational on req_src. The result and tag are written into the FIFO tail on acceptance.
- Latency: a request accepted at edge N with an empty FIFO gives rsp_valid = 1 with that result immediately after edge N. Minimum 1 cycle.
- FIFO:
  - count is 0..DEPTH.
  - push = req_valid & req_ready; pop = rsp_valid & rsp_ready.
  - Simultaneous push and pop leaves count unchanged and preserves order.
  - Read/write pointers wrap modulo DEPTH.
- Ready/valid outputs:
  - req_ready = ready_q & (count != DEPTH). There is no full-FIFO pass-through: when full, req_ready = 0 even if rsp_ready = 1.
  - ready_q is a register reset to 0 and set to 1 on the first clk edge after nrst deasserts.
  - rsp_valid = (count != 0).
  - rsp_res and rsp_tag show the head entry when valid, and all zeros when empty.
- Response stability: while rsp_valid & ~rsp_ready, rsp_res and rsp_tag hold stable.
- flush:
  - At the edge: count <- 0, pointers <- 0, snan_seen <- 0. Any push or pop in the same cycle is discarded.
  - req_ready remains governed by the rule above; the cycle after flush it is 1.
- snan_seen: set at the edge accepting an snan operand. Cleared only by flush or reset. Flush has priority over set.
- Reset (nrst low, asynchronous, mid-operation included):
  - req_ready = 0, rsp_valid = 0, rsp_res = 0, rsp_tag = 0, snan_seen = 0.
  - count = 0, pointers = 0.
  - All FIFO contents are discarded. No response from before reset is ever delivered.
- Elaboration check: an illegal parameter combination (FMT_W > FLEN, DEPTH < 1) must produce an error.

Test Plan:
- Default params. Send src 0x7FC00000, 0x7F800001, 0xFF800000, 0x80000001, 0x00000000, 0x3F800000 with tags 0..5 and rsp_ready = 1. Required masks in order: 0x200, 0x100, 0x001, 0x004, 0x010, 0x040. Tags return 0..5, each 1 cycle after acceptance. snan_seen = 1 after the second request.
- FLEN=64, EXP_W=8, MAN_W=23.
  - src 0xFFFFFFFF_3F800000 gives 0x040.
  - src 0x00000000_3F800000 gives 0x200.
  - src 0x00000000_7F800001 gives 0x200 and snan_seen stays 0.
- FLEN=16, EXP_W=5, MAN_W=10.
  - 0x7C00 gives 0x080; 0x0001 gives 0x020; 0x8000 gives 0x008; 0xFE00 gives 0x200.
- Backpressure, DEPTH=2, rsp_ready = 0. Push tags A and B; req_ready drops to 0 after the second push while a third request stays pending. Raise rsp_ready: A pops, then the third request is accepted. Output order is A, B, C, and rsp_res holds stable while stalled.
- Simultaneous push/pop with count = 1: count stays 1 and order is preserved.
- Flush with count = 2 and snan_seen = 1: next cycle rsp_valid = 0, rsp_res = 0, snan_seen = 0, req_ready = 1.
- Assert nrst low asynchronously between edges with count = 2: outputs go to reset values immediately. After release, req_ready = 0 for one edge, then 1. No stale response appears.
